// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   mdu_op_t    : 3-bit operation code presented on the op port
//   mdu_state_t : sequencer state (idle, iterate, sign fix/commit)
//   MDU_STEPS   : radix-2 iterations per arithmetic operation
//   mag()       : magnitude of an operand, optionally treating it as signed
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } mdu_state_t;

  localparam int unsigned MDU_STEPS = 32;

  // 0x80000000 yields 0x80000000, which read unsigned is the required 2^31.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step.
//   rem      : current partial remainder (always < divisor)
//   shift_in : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this step
module mdu_divstep (
  input  logic [31:0] rem,
  input  logic        shift_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted  = {rem, shift_in};
    diff     = shifted - {1'b0, divisor};
    // A borrow out of bit 32 means the trial subtraction went negative.
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : shifted[31:0];
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   start : request strobe, ignored while busy
//   op    : operation (mdu_op_t)
//   a, b  : rs / rt operands
//   busy  : arithmetic operation in progress
//   done  : one-cycle pulse after HI/LO are written by an arithmetic op
//   hi,lo : architectural HI / LO
module mdu_hilo
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [31:0] a_q, a_d;          // raw dividend, returned in HI on divide by zero
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;
  logic [31:0] rem_next;
  logic        q_bit;

  mdu_divstep u_divstep (
    .rem      (acc_q[63:32]),
    .shift_in (acc_q[31]),
    .divisor  (opnd_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    signed_op = (op == OpMult) || (op == OpDiv);
    // Shift-add: add multiplicand into the upper half on a set LSB, then shift right.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    prod_fix  = neg_res_q ? (~acc_q + 64'd1) : acc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              is_div_d  = (op == OpDiv) || (op == OpDivu);
              neg_res_d = signed_op && (a[31] ^ b[31]);
              neg_rem_d = signed_op && a[31];
              div0_d    = (b == 32'd0);
              a_d       = a;
              cnt_d     = 6'd0;
              busy_d    = 1'b1;
              state_d   = StRun;
              if (is_div_d) begin
                acc_d  = {32'd0, mag(a, signed_op)};
                opnd_d = mag(b, signed_op);
              end else begin
                acc_d  = {32'd0, mag(b, signed_op)};
                opnd_d = mag(a, signed_op);
              end
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        acc_d = is_div_q ? {rem_next, acc_q[30:0], q_bit} : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MDU_STEPS - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
          lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        end
        cnt_d   = 6'd0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      a_q       <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed corner cases plus randomized ops,
// compared against a plain-arithmetic model of HI/LO.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  mdu_op_t     op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu_hilo dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural result {hi, lo} of one op, from the ISA rules.
  function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    longint sx, sy, p;
    int     ix, iy;
    logic [63:0] up;
    case (o)
      OpMult: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
        return p;
      end
      OpMultu: begin
        up = {32'd0, x} * {32'd0, y};
        return up;
      end
      OpDiv: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ix = $signed(x);
        iy = $signed(y);
        return {32'(ix % iy), 32'(ix / iy)};
      end
      OpDivu: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      OpMthi:  return {x, cur[31:0]};
      OpMtlo:  return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction

  // Issue an arithmetic op; optionally try to start other ops while busy.
  task automatic do_arith(input string tag, input mdu_op_t o, input logic [31:0] x,
                          input logic [31:0] y, input bit inject);
    logic [63:0] exp;
    int          n;
    bit          bad;
    exp = model(o, x, y, {hi_m, lo_m});
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    n   = 0;
    bad = 1'b0;
    while (busy && n < 100) begin
      if (hi !== hi_m || lo !== lo_m || done !== 1'b0) bad = 1'b1;
      if (inject && (n == 5 || n == 31)) begin
        start = 1'b1;
        op    = (n == 5) ? OpMtlo : OpMult;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0007;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_busy_len"}, 64'(n), 64'd33);
    check({tag, "_hold"}, 64'(bad), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    check({tag, "_hi"}, 64'(hi), 64'(hi_m));
    check({tag, "_lo"}, 64'(lo), 64'(lo_m));
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 64'(done), 64'd0);
  endtask

  task automatic do_move(input string tag, input mdu_op_t o, input logic [31:0] x);
    logic [63:0] exp;
    exp = model(o, x, 32'd0, {hi_m, lo_m});
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    check({tag, "_hilo"}, {hi, lo}, {hi_m, lo_m});
    check({tag, "_flags"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    mdu_op_t     ro;
    logic [31:0] ra, rb;
    bit          saw_done;

    reset = 1'b0; start = 1'b0; op = OpMult; a = 32'd0; b = 32'd0;
    #12;
    check("reset_state", {28'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_arith("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_arith("mult_neg3x5", OpMult, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_arith("mult_minmin", OpMult, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_arith("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_arith("divu_7_2", OpDivu, 32'd7, 32'd2, 1'b0);
    do_arith("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_arith("divu_by0", OpDivu, 32'd100, 32'd0, 1'b0);
    do_arith("div_by0", OpDiv, 32'hFFFF_FFFB, 32'd0, 1'b0);
    do_move("mthi", OpMthi, 32'h0000_1234);
    do_move("mtlo", OpMtlo, 32'h0BAD_F00D);
    do_arith("busy_ignore", OpMultu, 32'h0001_0003, 32'h0002_0005, 1'b1);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = OpDiv; a = 32'h1234_5678; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("reset_mid", {31'd0, busy, hi, lo}, 64'd0);
    saw_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("reset_no_done", 64'(saw_done), 64'd0);
    do_arith("post_reset_mult", OpMult, 32'h0000_0100, 32'hFFFF_FF00, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ro = mdu_op_t'($urandom_range(0, 5));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom();
      endcase
      if (ro == OpMthi || ro == OpMtlo) do_move($sformatf("rnd%0d", i), ro, ra);
      else do_arith($sformatf("rnd%0d", i), ro, ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
